// File: rtl/ffcp_tx_server_if.sv
// Handshake bundle between the FFCP sender flow control and its neighbours
// (upstream buffer, ffcp_tx and ffcp_rx ack decode).
interface ffcp_tx_server_if #(
  parameter int unsigned FFCP_INDEX_LEN = 6
);
  logic                      syn_req;
  logic [FFCP_INDEX_LEN-1:0] wr_index;
  logic                      ack_inclk;
  logic [FFCP_INDEX_LEN-1:0] ack_index;
  logic                      tx_start;
  logic [1:0]                tx_type;
  logic [FFCP_INDEX_LEN-1:0] tx_index;
  logic                      tx_done;
  logic [FFCP_INDEX_LEN-1:0] base_index;
  logic                      synced;
  logic                      busy;

  modport master (
    output syn_req, wr_index, ack_inclk, ack_index, tx_done,
    input  tx_start, tx_type, tx_index, base_index, synced, busy
  );

  modport slave (
    input  syn_req, wr_index, ack_inclk, ack_index, tx_done,
    output tx_start, tx_type, tx_index, base_index, synced, busy
  );
endinterface

// File: rtl/ffcp_tx_server.sv
// FFCP sender flow control: SYN session open, fixed window go-back-N with cumulative
// acks and timeout rewind. Supplies packet type/index to ffcp_tx.
module ffcp_tx_server #(
  parameter int unsigned FFCP_INDEX_LEN  = 6,
  parameter int unsigned FFCP_WINDOW_LEN = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
  input logic              clk,
  input logic              rst_n,
  ffcp_tx_server_if.slave  bus
);

  localparam int unsigned IdxW   = FFCP_INDEX_LEN;
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IdxW:0]     WinLen     = (IdxW + 1)'(FFCP_WINDOW_LEN);
  localparam logic [TimerW-1:0] TimeoutVal = TimerW'(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerOne   = TimerW'(1);
  localparam logic [IdxW-1:0]   IdxOne     = IdxW'(1);
  localparam logic [1:0]        TypeSyn    = 2'd0;
  localparam logic [1:0]        TypeMsg    = 2'd1;

  typedef enum logic [1:0] {
    StIdle,
    StReady,
    StWaitDone
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   base_q, base_d;
  logic [IdxW-1:0]   next_q, next_d;
  logic [IdxW-1:0]   high_q, high_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              syn_pend_q, syn_pend_d;
  logic              synced_q, synced_d;
  logic              tx_start_q, tx_start_d;
  logic [1:0]        tx_type_q, tx_type_d;
  logic [IdxW-1:0]   tx_index_q, tx_index_d;

  logic [IdxW-1:0]   ack_dist;
  logic [IdxW-1:0]   in_flight;
  logic [IdxW-1:0]   send_dist;
  logic [IdxW-1:0]   launch_dist;
  logic              ack_valid;
  logic              open_session;
  logic              may_launch;
  logic              launch;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    next_d       = next_q;
    high_d       = high_q;
    timer_d      = timer_q;
    syn_pend_d   = syn_pend_q;
    synced_d     = synced_q;
    tx_start_d   = 1'b0;
    tx_type_d    = tx_type_q;
    tx_index_d   = tx_index_q;
    open_session = 1'b0;
    may_launch   = 1'b0;
    launch       = 1'b0;

    // All window arithmetic is distance from base, so index wrap is transparent.
    ack_dist  = bus.ack_index - base_q;
    in_flight = high_q - base_q;
    send_dist = next_q - base_q;
    ack_valid = (state_q != StIdle) && bus.ack_inclk &&
                (ack_dist != '0) && (ack_dist <= in_flight);

    unique case (state_q)
      StIdle: begin
        open_session = bus.syn_req;
        may_launch   = bus.syn_req;
      end
      StReady: begin
        open_session = bus.syn_req | syn_pend_q;
        may_launch   = 1'b1;
      end
      StWaitDone: begin
        if (bus.syn_req) syn_pend_d = 1'b1;
        if (bus.tx_done) state_d = StReady;
      end
      default: state_d = StIdle;
    endcase

    if (open_session) begin
      base_d     = '0;
      next_d     = '0;
      high_d     = '0;
      timer_d    = '0;
      synced_d   = 1'b0;
      syn_pend_d = 1'b0;
      state_d    = StReady;
    end else if (ack_valid) begin
      // A valid ack always beats a coincident timeout.
      base_d  = bus.ack_index;
      timer_d = '0;
      if (ack_dist > send_dist) next_d = bus.ack_index;
      if ((base_q == '0) && !synced_q) synced_d = 1'b1;
    end else if (base_q == high_q) begin
      timer_d = '0;
    end else if (timer_q != TimeoutVal) begin
      timer_d = timer_q + TimerOne;
    end else if (state_q == StReady) begin
      next_d  = base_q;
      timer_d = '0;
    end

    // Launch decision sees this cycle's ack/rewind so a freed window is used at once.
    launch_dist = next_d - base_d;
    if (may_launch) begin
      if (!synced_d && (next_d == '0)) begin
        launch    = 1'b1;
        tx_type_d = TypeSyn;
      end else if (synced_d && (next_d != bus.wr_index) &&
                   ({1'b0, launch_dist} < WinLen)) begin
        launch    = 1'b1;
        tx_type_d = TypeMsg;
      end
    end

    if (launch) begin
      tx_start_d = 1'b1;
      tx_index_d = next_d;
      next_d     = next_d + IdxOne;
      if ((next_d - base_d) > (high_d - base_d)) high_d = next_d;
      state_d = StWaitDone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_q     <= '0;
      next_q     <= '0;
      high_q     <= '0;
      timer_q    <= '0;
      syn_pend_q <= 1'b0;
      synced_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_type_q  <= 2'd0;
      tx_index_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      next_q     <= next_d;
      high_q     <= high_d;
      timer_q    <= timer_d;
      syn_pend_q <= syn_pend_d;
      synced_q   <= synced_d;
      tx_start_q <= tx_start_d;
      tx_type_q  <= tx_type_d;
      tx_index_q <= tx_index_d;
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_type    = tx_type_q;
  assign bus.tx_index   = tx_index_q;
  assign bus.base_index = base_q;
  assign bus.synced     = synced_q;
  assign bus.busy       = (state_q == StWaitDone);

endmodule

// File: tb/tb_ffcp_tx_server.sv
// Directed bench for ffcp_tx_server: vector tables for send/ack/idle sequences plus
// hand-written timeout, ack-vs-timeout and mid-packet reset sequences.
module tb_ffcp_tx_server;

  localparam int T = 60;

  typedef enum int {OpWr, OpAck, OpSend, OpQuiet} op_e;

  typedef struct {
    op_e        op;
    logic [5:0] arg;
    logic [5:0] exp_idx;
    logic [5:0] exp_base;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  ffcp_tx_server_if #(.FFCP_INDEX_LEN(6)) bus ();

  ffcp_tx_server #(
    .FFCP_INDEX_LEN (6),
    .FFCP_WINDOW_LEN(8),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input op_e op, input logic [5:0] arg, input logic [5:0] ei,
                     input logic [5:0] eb);
    vec_t v;
    v.op = op;
    v.arg = arg;
    v.exp_idx = ei;
    v.exp_base = eb;
    vecs.push_back(v);
  endtask

  task automatic wait_start(input logic [5:0] idx, input logic [1:0] typ, input int bound);
    int c;
    c = 0;
    while (bus.tx_start !== 1'b1 && c < bound) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("tx_start_seen", 32'(bus.tx_start), 32'd1);
    check("tx_index", 32'(bus.tx_index), 32'(idx));
    check("tx_type", 32'(bus.tx_type), 32'(typ));
    check("busy_on_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic pulse_done();
    @(posedge clk);
    #1;
    bus.tx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_done = 1'b0;
  endtask

  task automatic do_ack(input logic [5:0] idx, input logic [5:0] exp_base);
    bus.ack_inclk = 1'b1;
    bus.ack_index = idx;
    @(posedge clk);
    #1;
    bus.ack_inclk = 1'b0;
    check("base_after_ack", 32'(bus.base_index), 32'(exp_base));
    check("synced_after_ack", 32'(bus.synced), 32'd1);
  endtask

  task automatic do_quiet(input int n, input logic [5:0] exp_base);
    logic any;
    any = bus.tx_start;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.tx_start !== 1'b0) any = 1'b1;
    end
    check("quiet_no_start", 32'(any), 32'd0);
    check("quiet_base", 32'(bus.base_index), 32'(exp_base));
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      unique case (vecs[i].op)
        OpWr:    bus.wr_index = vecs[i].arg;
        OpAck:   do_ack(vecs[i].arg, vecs[i].exp_base);
        OpSend: begin
          wait_start(vecs[i].exp_idx, 2'd1, 20);
          pulse_done();
        end
        OpQuiet: do_quiet(int'(vecs[i].arg), vecs[i].exp_base);
        default: ;
      endcase
    end
    vecs.delete();
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.syn_req = 1'b0;
    bus.wr_index = 6'd1;
    bus.ack_inclk = 1'b0;
    bus.ack_index = 6'd0;
    bus.tx_done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_type", 32'(bus.tx_type), 32'd0);
    check("rst_tx_index", 32'(bus.tx_index), 32'd0);
    check("rst_base", 32'(bus.base_index), 32'd0);
    check("rst_synced", 32'(bus.synced), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SYN: tx_start on the edge that samples syn_req in IDLE
    bus.syn_req = 1'b1;
    @(posedge clk);
    #1;
    bus.syn_req = 1'b0;
    check("syn_start", 32'(bus.tx_start), 32'd1);
    check("syn_type", 32'(bus.tx_type), 32'd0);
    check("syn_index", 32'(bus.tx_index), 32'd0);
    check("syn_busy", 32'(bus.busy), 32'd1);
    check("syn_not_synced", 32'(bus.synced), 32'd0);
    pulse_done();

    // Ack of SYN, window fill/stall, ack reopen, empty, ignored acks
    add(OpAck, 6'd1, 6'd0, 6'd1);
    add(OpQuiet, 6'd5, 6'd0, 6'd1);
    add(OpWr, 6'd12, 6'd0, 6'd0);
    for (int i = 1; i <= 8; i++) add(OpSend, 6'd0, 6'(i), 6'd0);
    add(OpQuiet, 6'd6, 6'd0, 6'd1);
    add(OpAck, 6'd5, 6'd0, 6'd5);
    for (int i = 9; i <= 11; i++) add(OpSend, 6'd0, 6'(i), 6'd0);
    add(OpQuiet, 6'd6, 6'd0, 6'd5);
    add(OpAck, 6'd5, 6'd0, 6'd5);
    add(OpAck, 6'd13, 6'd0, 6'd5);
    add(OpQuiet, 6'd4, 6'd0, 6'd5);
    add(OpAck, 6'd12, 6'd0, 6'd12);
    run_vecs();

    // Timeout rewind with late ack during the resend
    bus.wr_index = 6'd16;
    for (int i = 12; i < 16; i++) begin
      wait_start(6'(i), 2'd1, 20);
      pulse_done();
    end
    wait_start(6'd12, 2'd1, 3 * T);
    do_ack(6'd14, 6'd14);
    pulse_done();
    wait_start(6'd14, 2'd1, 20);
    pulse_done();
    wait_start(6'd15, 2'd1, 20);
    pulse_done();
    do_ack(6'd16, 6'd16);

    // Advance to base 60, then wrap
    bus.wr_index = 6'd60;
    for (int i = 16; i < 60; i++) begin
      wait_start(6'(i), 2'd1, 20);
      pulse_done();
      do_ack(6'(i + 1), 6'(i + 1));
    end
    add(OpWr, 6'd4, 6'd0, 6'd0);
    for (int i = 60; i < 68; i++) add(OpSend, 6'd0, 6'(i), 6'd0);
    add(OpQuiet, 6'd4, 6'd0, 6'd60);
    add(OpAck, 6'd2, 6'd0, 6'd2);
    add(OpWr, 6'd6, 6'd0, 6'd0);
    add(OpSend, 6'd0, 6'd4, 6'd0);
    add(OpSend, 6'd0, 6'd5, 6'd0);
    add(OpAck, 6'd6, 6'd0, 6'd6);
    run_vecs();

    // Ack arriving in the very cycle the timer saturates: no rewind
    bus.wr_index = 6'd7;
    wait_start(6'd6, 2'd1, 20);
    bus.tx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_done = 1'b0;
    repeat (T - 1) @(posedge clk);
    #1;
    bus.ack_inclk = 1'b1;
    bus.ack_index = 6'd7;
    @(posedge clk);
    #1;
    bus.ack_inclk = 1'b0;
    check("tie_base", 32'(bus.base_index), 32'd7);
    check("tie_no_start", 32'(bus.tx_start), 32'd0);
    do_quiet(5, 6'd7);

    // Asynchronous reset in the middle of a packet
    bus.wr_index = 6'd9;
    wait_start(6'd7, 2'd1, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("mid_rst_tx_type", 32'(bus.tx_type), 32'd0);
    check("mid_rst_tx_index", 32'(bus.tx_index), 32'd0);
    check("mid_rst_base", 32'(bus.base_index), 32'd0);
    check("mid_rst_synced", 32'(bus.synced), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulse_done();
    bus.ack_inclk = 1'b1;
    bus.ack_index = 6'd1;
    @(posedge clk);
    #1;
    bus.ack_inclk = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_synced", 32'(bus.synced), 32'd0);
    check("idle_base", 32'(bus.base_index), 32'd0);
    check("idle_no_start", 32'(bus.tx_start), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
